// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg                                                          |
// | Shared types and constants for the unified memory port arbiter.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int c_MEM_LAT_MAX = 4;
  localparam int c_LAT_CNT_W   = $clog2(c_MEM_LAT_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_port_arbiter                                                     |
// | Shares one single-port memory between fetch and load/store with data |
// | priority. Define MEM_ARB_STARVE_GUARD_EN to add the fetch starvation |
// | guard (forces a fetch grant after STREAK_MAX data grants).           |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
`ifdef MEM_ARB_STARVE_GUARD_EN
  ,
  parameter int STREAK_MAX = 4
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_rvalid,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t                 r_state;
  state_t                 w_next_state;
  owner_t                 r_owner;
  logic [c_LAT_CNT_W-1:0] r_lat_cnt;

  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_gnt;
  logic              r_dm_gnt;
  logic              r_if_rvalid;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
  logic              r_busy;

  logic w_pick_dm;
  logic w_pick_if;

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int                    c_STREAK_W   = $clog2(STREAK_MAX + 1);
  localparam logic [c_STREAK_W-1:0] c_STREAK_TOP = c_STREAK_W'(STREAK_MAX);

  logic [c_STREAK_W-1:0] r_streak;
  logic                  w_force_if;

  assign w_force_if = dm_req && if_req && (r_streak == c_STREAK_TOP);
  assign w_pick_dm  = dm_req && !w_force_if;

  // Counts data wins that made a waiting fetch lose; saturates at the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_streak <= '0;
    end else if (r_state == IDLE) begin
      if (w_pick_if) begin
        r_streak <= '0;
      end else if (w_pick_dm && if_req && (r_streak != c_STREAK_TOP)) begin
        r_streak <= r_streak + 1'b1;
      end
    end
  end
`else
  assign w_pick_dm = dm_req;
`endif

  assign w_pick_if = if_req && !w_pick_dm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_dm || w_pick_if) begin
          w_next_state = ISSUE;
        end
      end
      ISSUE: begin
        if (r_mem_we) begin
          w_next_state = IDLE;
        end else if (MEM_LAT > 1) begin
          w_next_state = WAIT;
        end else begin
          w_next_state = RESP;
        end
      end
      WAIT: begin
        if (r_lat_cnt == '0) begin
          w_next_state = RESP;
        end
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Grant, enable and rvalid are single-cycle pulses; everything else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner     <= OWN_IF;
      r_lat_cnt   <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rdata  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_if_gnt    <= 1'b0;
      r_dm_gnt    <= 1'b0;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      r_busy      <= (w_next_state != IDLE);
      case (r_state)
        IDLE: begin
          if (w_pick_dm) begin
            r_owner     <= OWN_DM;
            r_mem_en    <= 1'b1;
            r_mem_we    <= dm_we;
            r_mem_addr  <= dm_addr;
            r_mem_wdata <= dm_wdata;
            r_dm_gnt    <= 1'b1;
          end else if (w_pick_if) begin
            r_owner    <= OWN_IF;
            r_mem_en   <= 1'b1;
            r_mem_addr <= if_addr;
            r_if_gnt   <= 1'b1;
          end
        end
        ISSUE: begin
          // WAIT spans MEM_LAT-1 cycles: count MEM_LAT-2 down to zero.
          r_lat_cnt <= c_LAT_CNT_W'(MEM_LAT - 2);
        end
        WAIT: begin
          r_lat_cnt <= r_lat_cnt - 1'b1;
        end
        RESP: begin
          if (r_owner == OWN_DM) begin
            r_dm_rdata  <= mem_rdata;
            r_dm_rvalid <= 1'b1;
          end else begin
            r_if_rdata  <= mem_rdata;
            r_if_rvalid <= 1'b1;
          end
        end
        default: begin
          r_lat_cnt <= '0;
        end
      endcase
    end
  end

  assign if_gnt    = r_if_gnt;
  assign if_rvalid = r_if_rvalid;
  assign if_rdata  = r_if_rdata;
  assign dm_gnt    = r_dm_gnt;
  assign dm_rvalid = r_dm_rvalid;
  assign dm_rdata  = r_dm_rdata;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// Bench for mem_port_arbiter: instance A uses MEM_LAT=1, instance B MEM_LAT=4;
// both read a shared behavioural memory, only A ever stores.
module tb_mem_port_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];

  // Instance A signals
  logic        a_rst_n, a_if_req, a_dm_req, a_dm_we;
  logic [9:0]  a_if_addr, a_dm_addr, a_mem_addr;
  logic [31:0] a_dm_wdata, a_if_rdata, a_dm_rdata, a_mem_wdata, a_mem_rdata;
  logic        a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_en, a_mem_we, a_busy;

  // Instance B signals
  logic        b_rst_n, b_if_req, b_dm_req, b_dm_we;
  logic [9:0]  b_if_addr, b_dm_addr, b_mem_addr;
  logic [31:0] b_dm_wdata, b_if_rdata, b_dm_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_if_gnt, b_if_rvalid, b_dm_gnt, b_dm_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_pipe [0:3];

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT_A)) u_dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
    .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
    .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid), .dm_rdata(a_dm_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  mem_port_arbiter #(.ADDR_W(10), .DATA_W(32), .MEM_LAT(LAT_B)) u_dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
    .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
    .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid), .dm_rdata(b_dm_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory model: preloads while A is in reset, A reads/writes with 1-cycle latency.
  always @(posedge clk) begin
    if (!a_rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
      mem[5] <= 32'hDEAD_BEEF;
    end else if (a_mem_en) begin
      if (a_mem_we) mem[a_mem_addr] <= a_mem_wdata;
      else          a_mem_rdata     <= mem[a_mem_addr];
    end
  end

  // B: 4-cycle read pipeline, read-only.
  always @(posedge clk) begin
    if (b_mem_en && !b_mem_we) b_pipe[0] <= mem[b_mem_addr];
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
    b_pipe[3] <= b_pipe[2];
  end
  assign b_mem_rdata = b_pipe[3];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        is_dm;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic run_a(input vec_t v);
    int k;
    int rv;
    @(negedge clk);
    if (v.is_dm) begin
      a_dm_req = 1'b1; a_dm_we = v.we; a_dm_addr = v.addr; a_dm_wdata = v.wdata;
    end else begin
      a_if_req = 1'b1; a_if_addr = v.addr;
    end
    @(posedge clk); #1;
    check("grant_select", {a_dm_gnt, a_if_gnt}, {v.is_dm, !v.is_dm});
    check("issue_port", {a_mem_en, a_mem_we, a_busy, a_mem_addr}, {1'b1, v.we, 1'b1, v.addr});
    a_dm_req = 1'b0; a_if_req = 1'b0;
    if (v.we) begin
      check("store_wdata", a_mem_wdata, v.wdata);
      rv = 0;
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (a_dm_rvalid || a_if_rvalid) rv++;
      end
      check("store_no_rvalid", rv, 0);
      check("store_idle", a_busy, 1'b0);
    end else begin
      k = 9;
      for (int c = 1; c <= 8; c++) begin
        @(posedge clk); #1;
        if (a_if_rvalid || a_dm_rvalid) begin k = c; break; end
      end
      check("load_latency", k, LAT_A + 1);
      check("rvalid_route", {a_dm_rvalid, a_if_rvalid}, {v.is_dm, !v.is_dm});
      check("load_rdata", v.is_dm ? a_dm_rdata : a_if_rdata, v.exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int k, dm_before, dm_after, seen_if, if_rv, dm_rv;

    vecs[0] = '{1'b0, 1'b0, 10'h005, 32'h0,         32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 1'b1, 10'h3FF, 32'h1234_5678, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 10'h3FF, 32'h0,         32'h1234_5678};
    vecs[3] = '{1'b0, 1'b0, 10'h010, 32'h0,         32'hC0DE_0010};
    vecs[4] = '{1'b1, 1'b1, 10'h000, 32'hCAFE_F00D, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 10'h000, 32'h0,         32'hCAFE_F00D};
    vecs[6] = '{1'b0, 1'b0, 10'h000, 32'h0,         32'hCAFE_F00D};
    vecs[7] = '{1'b1, 1'b0, 10'h200, 32'h0,         32'hC0DE_0200};

    a_rst_n = 1'b0; a_if_req = 1'b1; a_if_addr = 10'h005;
    a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_addr = '0; a_dm_wdata = '0;
    b_rst_n = 1'b0; b_if_req = 1'b0; b_if_addr = '0;
    b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;

    // Reset held while fetch requests
    repeat (3) @(posedge clk);
    #1;
    check("reset_flags", {a_if_gnt, a_if_rvalid, a_dm_gnt, a_dm_rvalid, a_mem_en, a_mem_we, a_busy}, 7'b0);
    check("reset_port", {a_mem_addr, a_mem_wdata}, 42'h0);
    check("reset_rdata", {a_if_rdata, a_dm_rdata}, 64'h0);
    @(negedge clk); a_rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_if_gnt", a_if_gnt, 1'b1);
    a_if_req = 1'b0;
    k = 9;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (a_if_rvalid) begin k = c; break; end
    end
    check("post_reset_latency", k, LAT_A + 1);
    check("post_reset_rdata", a_if_rdata, 32'hDEAD_BEEF);

    for (int i = 0; i < 8; i++) run_a(vecs[i]);

    // Simultaneous requests: data first, fetch next, data routed separately
    @(negedge clk);
    a_if_req = 1'b1; a_if_addr = 10'h005;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 10'h3FF;
    @(posedge clk); #1;
    check("both_dm_first", {a_dm_gnt, a_if_gnt}, 2'b10);
    a_dm_req = 1'b0;
    k = 0; if_rv = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (a_if_rvalid) if_rv++;
      if (a_dm_rvalid) begin k = c; break; end
    end
    check("both_dm_rvalid", k, LAT_A + 1);
    check("both_dm_rdata", a_dm_rdata, 32'h1234_5678);
    k = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (a_if_rvalid) if_rv++;
      if (a_if_gnt) begin k = c; break; end
    end
    check("both_if_gnt_next", k, 1);
    a_if_req = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (a_if_rvalid) begin if_rv++; break; end
    end
    check("both_if_rvalid_once", if_rv, 1);
    check("both_if_rdata", a_if_rdata, 32'hDEAD_BEEF);
    check("both_dm_rdata_held", a_dm_rdata, 32'h1234_5678);

    // Continuous data loads with a fetch pending
    @(negedge clk);
    a_if_req = 1'b1; a_if_addr = 10'h010;
    a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 10'h000;
    dm_before = 0; dm_after = 0; seen_if = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      if (a_dm_gnt) begin
        if (seen_if != 0) dm_after++;
        else              dm_before++;
      end
      if (a_if_gnt) begin seen_if = 1; a_if_req = 1'b0; end
      if (a_if_rvalid) check("streak_if_rdata", a_if_rdata, 32'hC0DE_0010);
      if (seen_if != 0 && dm_after > 0) break;
    end
`ifdef MEM_ARB_STARVE_GUARD_EN
    check("guard_dm_before_if", dm_before, 4);
    check("guard_if_served", seen_if, 1);
    check("guard_dm_resumes", dm_after > 0, 1'b1);
    @(negedge clk); a_dm_req = 1'b0;
    repeat (8) @(posedge clk);
`else
    check("strict_no_if_gnt", seen_if, 0);
    check("strict_dm_streak", dm_before >= 5, 1'b1);
    @(negedge clk); a_dm_req = 1'b0;
    k = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (a_if_gnt) a_if_req = 1'b0;
      if (a_if_rvalid) begin k = c; break; end
    end
    check("strict_if_eventually", k != 0, 1'b1);
    check("strict_if_rdata", a_if_rdata, 32'hC0DE_0010);
`endif

    // Instance B: MEM_LAT=4 latency, then reset during WAIT
    @(negedge clk); b_rst_n = 1'b1;
    @(negedge clk); b_if_req = 1'b1; b_if_addr = 10'h010;
    @(posedge clk); #1;
    check("b_if_gnt", b_if_gnt, 1'b1);
    b_if_req = 1'b0;
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (b_if_rvalid) begin k = c; break; end
    end
    check("b_load_latency", k, LAT_B + 1);
    check("b_if_rdata", b_if_rdata, 32'hC0DE_0010);

    @(negedge clk); b_dm_req = 1'b1; b_dm_we = 1'b0; b_dm_addr = 10'h020;
    @(posedge clk); #1;
    check("b_dm_gnt", b_dm_gnt, 1'b1);
    b_dm_req = 1'b0;
    @(posedge clk); #1;
    check("b_busy_in_wait", b_busy, 1'b1);
    @(negedge clk); b_rst_n = 1'b0;
    #1;
    check("b_abort_idle", {b_busy, b_mem_en, b_dm_rvalid}, 3'b000);
    @(negedge clk); b_rst_n = 1'b1;
    dm_rv = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (b_dm_rvalid || b_if_rvalid || b_busy) dm_rv++;
    end
    check("b_no_rvalid_after_abort", dm_rv, 0);
    check("b_dm_rdata_reset", b_dm_rdata, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
